icache_refill_unit: RTL
=======================

// Module: icache_refill_unit
// PURPOSE
//  Services one icache miss at a time: fetches a full line from the memory bus in
//  MEM_DATA_WIDTH beats and assembles them into a line buffer. Then writes the line
//  into the icache data array through its single write port (index/wdata/wen).
//  Sits between the fetch miss logic and the bus interface; it is the writer side of
//  the data array.
// PARAMETERS
//  ICACHE_DATA_WIDTH  256  line width in bits; must be a multiple of MEM_DATA_WIDTH
//  ICACHE_INTEX_WIDTH 6    data-array index width (number of sets = 2**N)
//  MEM_DATA_WIDTH     64   memory response beat width
//  ADDR_WIDTH         32   physical address width
//  Derived: BEATS = ICACHE_DATA_WIDTH/MEM_DATA_WIDTH (4)
//  Derived: OFS = log2(ICACHE_DATA_WIDTH/8) (5)
// PORTS
//  clk_i            in   1                   clock
//  rst_i            in   1                   synchronous reset, active-low
//  miss_valid_i     in   1                   miss request valid
//  miss_ready_o     out  1                   unit can accept a miss
//  miss_addr_i      in   ADDR_WIDTH          missing fetch address (any byte in line)
//  mem_req_valid_o  out  1                   line read request valid
//  mem_req_ready_i  in   1                   bus accepts request
//  mem_req_addr_o   out  ADDR_WIDTH          line-aligned request address
//  mem_rsp_valid_i  in   1                   response beat valid (no backpressure)
//  mem_rsp_data_i   in   MEM_DATA_WIDTH      response beat data
//  mem_rsp_err_i    in   1                   beat carries bus error
//  icache_index_o   out  ICACHE_INTEX_WIDTH  data-array write index
//  icache_wdata_o   out  ICACHE_DATA_WIDTH   data-array write data (line buffer)
//  icache_wen_o     out  1                   data-array write enable, 1-cycle pulse
//  refill_done_o    out  1                   pulse: line written successfully
//  refill_err_o     out  1                   pulse: refill ended with bus error, no write
// BEHAVIOUR
//  Reset (rst_i=0 at posedge): state=IDLE; beat_cnt, err, line address, line buffer = 0.
//   All outputs 0 except miss_ready_o=1.
//  FSM IDLE -> REQ -> FILL -> WRITE -> IDLE:
//   IDLE:  miss_ready_o=1. Accept on miss_valid_i&miss_ready_o.
//          Latch miss_addr_i with bits [OFS-1:0] cleared; clear err, beat_cnt -> REQ.
//   REQ:   mem_req_valid_o=1, mem_req_addr_o = latched address, stable until accepted.
//          Accept on mem_req_ready_i -> FILL.
//   FILL:  each mem_rsp_valid_i writes mem_rsp_data_i into buffer slot beat_cnt
//          (beat 0 -> bits [MEM_DATA_WIDTH-1:0], ascending); beat_cnt++.
//          err |= mem_rsp_err_i. Beat with beat_cnt==BEATS-1 -> WRITE.
//   WRITE: one cycle. icache_index_o = addr[OFS+ICACHE_INTEX_WIDTH-1:OFS].
//          err=0: icache_wen_o=1 and refill_done_o=1.
//          err=1: icache_wen_o=0 and refill_err_o=1. Then -> IDLE.
//  miss_ready_o=0 outside IDLE; a miss presented in REQ/FILL/WRITE stalls, no drop.
//  mem_rsp_valid_i outside FILL is ignored (no buffer/counter change).
//  Latency: icache_wen_o asserts exactly 1 cycle after the last beat's cycle.
//   Min miss-accept to wen = 2 + BEATS cycles (ready=1, one beat per cycle).
//  icache_wdata_o = line buffer register; icache_index_o held from the latched address.
//   Both are valid whenever icache_wen_o=1.
//  beat_cnt width = log2(BEATS); no wrap, FILL exits at BEATS-1.
//  Line buffer is not cleared between refills; every slot is overwritten before wen.
//  Reset mid-refill: abort immediately to IDLE; no wen/done/err pulse.
//   Late response beats after reset are ignored (state IDLE).
// TESTING
//  1 Basic: miss_addr=0x0000_1234; req ready same cycle; beats D0..D3 back-to-back.
//    -> req_addr=0x0000_1220, index=0x11, wdata={D3,D2,D1,D0}, wen+done at beat3+1.
//  2 Gapped beats and req_ready held low 5 cycles -> req_valid/addr stable throughout.
//    Beats assemble correctly; wen exactly one cycle.
//  3 Error: mem_rsp_err_i=1 on beat 1 only -> refill_err_o=1 after beat 3; wen=0, done=0.
//  4 Back-to-back misses A then B held valid: B not accepted until IDLE after A's WRITE.
//    Two wen pulses with correct indices.
//  5 Reset asserted after beat 2 -> next cycle state IDLE, miss_ready_o=1, no pulses.
//    Stray beats ignored; a new miss then completes normally.
//  6 Spurious mem_rsp_valid_i in IDLE/REQ -> no effect on subsequent line contents.

Source files
------------

// File: rtl/icache_refill_unit.sv
// Refill engine for the instruction cache. It takes one miss at a time, reads the whole line from
// the memory bus beat by beat, and then writes the line into the data array in a single cycle.
module icache_refill_unit #(
  parameter int ICACHE_DATA_WIDTH  = 256,
  parameter int ICACHE_INTEX_WIDTH = 6,
  parameter int MEM_DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH         = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          miss_valid_i,
  output logic                          miss_ready_o,
  input  logic [ADDR_WIDTH-1:0]         miss_addr_i,
  output logic                          mem_req_valid_o,
  input  logic                          mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0]         mem_req_addr_o,
  input  logic                          mem_rsp_valid_i,
  input  logic [MEM_DATA_WIDTH-1:0]     mem_rsp_data_i,
  input  logic                          mem_rsp_err_i,
  output logic [ICACHE_INTEX_WIDTH-1:0] icache_index_o,
  output logic [ICACHE_DATA_WIDTH-1:0]  icache_wdata_o,
  output logic                          icache_wen_o,
  output logic                          refill_done_o,
  output logic                          refill_err_o
);

  localparam int BEATS = ICACHE_DATA_WIDTH / MEM_DATA_WIDTH;
  localparam int OFS   = $clog2(ICACHE_DATA_WIDTH / 8);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] OFS_MASK  = ADDR_WIDTH'((64'd1 << OFS) - 64'd1);

  typedef enum logic [1:0] {IDLE, REQ, FILL, WRITE} state_t;

  state_t                    state_reg, state_next;
  logic [CNT_W-1:0]          beat_cnt_reg, beat_cnt_next;
  logic                      err_reg, err_next;
  logic [ADDR_WIDTH-1:0]     addr_reg, addr_next;
  logic [MEM_DATA_WIDTH-1:0] slot_reg [BEATS];
  logic                      beat_fire;

  assign beat_fire = (state_reg == FILL) && mem_rsp_valid_i;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_reg    <= IDLE;
      beat_cnt_reg <= '0;
      err_reg      <= 1'b0;
      addr_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      beat_cnt_reg <= beat_cnt_next;
      err_reg      <= err_next;
      addr_reg     <= addr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    beat_cnt_next = beat_cnt_reg;
    err_next      = err_reg;
    addr_next     = addr_reg;
    case (state_reg)
      IDLE: begin
        if (miss_valid_i) begin
          addr_next     = miss_addr_i & ~OFS_MASK;
          err_next      = 1'b0;
          beat_cnt_next = '0;
          state_next    = REQ;
        end
      end
      REQ: begin
        if (mem_req_ready_i) state_next = FILL;
      end
      FILL: begin
        if (mem_rsp_valid_i) begin
          err_next = err_reg | mem_rsp_err_i;
          // Counter parks on the last slot rather than wrapping.
          if (beat_cnt_reg == LAST_BEAT) state_next = WRITE;
          else beat_cnt_next = beat_cnt_reg + CNT_W'(1);
        end
      end
      WRITE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Each line slot is captured only on the beat whose sequence number matches its position.
  genvar gi;
  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_slot
      always_ff @(posedge clk_i) begin
        if (!rst_i) slot_reg[gi] <= '0;
        else if (beat_fire && (beat_cnt_reg == CNT_W'(gi))) slot_reg[gi] <= mem_rsp_data_i;
      end
      assign icache_wdata_o[gi*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] = slot_reg[gi];
    end
  endgenerate

  assign miss_ready_o    = (state_reg == IDLE);
  assign mem_req_valid_o = (state_reg == REQ);
  assign mem_req_addr_o  = addr_reg;
  assign icache_index_o  = addr_reg[OFS +: ICACHE_INTEX_WIDTH];
  assign icache_wen_o    = (state_reg == WRITE) && !err_reg;
  assign refill_done_o   = (state_reg == WRITE) && !err_reg;
  assign refill_err_o    = (state_reg == WRITE) && err_reg;

endmodule
